// File: rtl/branch_update_queue.sv
// branch_update_queue: buffers resolved conditional branches and writes their
// outcomes into the branch history table through a lookup/allocate/update
// handshake. Entries are processed strictly in arrival order.
//
// Ports:
//   clk                 - single clock, rising edge
//   reset               - asynchronous, active-low reset
//   resolve_valid       - execute stage presents a resolved branch
//   resolve_pc          - PC of the resolved branch
//   resolve_taken       - branch outcome (1 = taken)
//   resolve_ready       - queue can accept an entry this cycle (not full)
//   bht_stall           - history table busy; no new lookup may start
//   tag_not_added       - table reports the presented tag is absent (comb from pc_bits)
//   pc_bits             - PC presented to the history table
//   increment_decrement - counter direction (1 = increment / taken)
//   update_en           - one-cycle strobe; table applies the update at this edge
//   occupancy           - number of queued entries
//   overflow            - sticky flag, set when an entry arrives while full
module branch_update_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     resolve_valid,
  input  logic [15:0]              resolve_pc,
  input  logic                     resolve_taken,
  output logic                     resolve_ready,
  input  logic                     bht_stall,
  input  logic                     tag_not_added,
  output logic [15:0]              pc_bits,
  output logic                     increment_decrement,
  output logic                     update_en,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  typedef struct packed {
    logic [15:0] pc;
    logic        taken;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    ALLOC  = 2'd2,
    UPDATE = 2'd3
  } state_t;

  state_t         state, state_nxt;
  entry_t         mem [DEPTH];
  entry_t         head;
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic           full, empty, push, pop;
  logic [15:0]    pc_nxt;
  logic           inc_nxt;

  assign full          = (occupancy == OW'(DEPTH));
  assign empty         = (occupancy == '0);
  assign resolve_ready = ~full;
  // Ready reflects pre-edge fullness, so a pop in the same cycle does not free a slot early.
  assign push          = resolve_valid & ~full;
  assign pop           = update_en;
  assign head          = mem[rd_ptr];

  // Entry storage; no reset needed, validity is tracked by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: resolve_pc, taken: resolve_taken};
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) begin
        occupancy <= occupancy + OW'(1);
      end else if (!push && pop) begin
        occupancy <= occupancy - OW'(1);
      end
      if (resolve_valid && full) overflow <= 1'b1;
    end
  end

  // State and table-facing registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      pc_bits             <= '0;
      increment_decrement <= 1'b0;
    end else begin
      state               <= state_nxt;
      pc_bits             <= pc_nxt;
      increment_decrement <= inc_nxt;
    end
  end

  // Next-state logic. pc_bits is loaded from the head when leaving IDLE and held
  // until the transaction finishes; update_en must be combinational because a hit
  // is known only from tag_not_added during LOOKUP.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_bits;
    inc_nxt   = increment_decrement;
    update_en = 1'b0;
    unique case (state)
      IDLE: begin
        pc_nxt  = '0;
        inc_nxt = 1'b0;
        if (!empty && !bht_stall) begin
          state_nxt = LOOKUP;
          pc_nxt    = head.pc;
          inc_nxt   = head.taken;
        end
      end
      LOOKUP: begin
        if (tag_not_added) begin
          state_nxt = ALLOC;
        end else begin
          update_en = 1'b1;
          state_nxt = IDLE;
          pc_nxt    = '0;
          inc_nxt   = 1'b0;
        end
      end
      ALLOC: begin
        state_nxt = UPDATE;
      end
      UPDATE: begin
        update_en = 1'b1;
        state_nxt = IDLE;
        pc_nxt    = '0;
        inc_nxt   = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        pc_nxt    = '0;
        inc_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed testbench for branch_update_queue.
module tb_branch_update_queue;

  logic        clk;
  logic        reset;
  logic        resolve_valid;
  logic [15:0] resolve_pc;
  logic        resolve_taken;
  logic        resolve_ready;
  logic        bht_stall;
  logic        tag_not_added;
  logic [15:0] pc_bits;
  logic        increment_decrement;
  logic        update_en;
  logic [2:0]  occupancy;
  logic        overflow;

  int tests_run;
  int tests_failed;
  int strobes;
  logic [16:0] log_q [$];

  branch_update_queue #(.DEPTH(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .resolve_valid       (resolve_valid),
    .resolve_pc          (resolve_pc),
    .resolve_taken       (resolve_taken),
    .resolve_ready       (resolve_ready),
    .bht_stall           (bht_stall),
    .tag_not_added       (tag_not_added),
    .pc_bits             (pc_bits),
    .increment_decrement (increment_decrement),
    .update_en           (update_en),
    .occupancy           (occupancy),
    .overflow            (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every strobe mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset && update_en) begin
      log_q.push_back({pc_bits, increment_decrement});
      strobes++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    tests_run++; if (resolve_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", resolve_ready); end
    tests_run++; if (occupancy !== 3'd0) begin tests_failed++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    tests_run++; if (update_en !== 1'b0) begin tests_failed++; $display("FAIL reset_upd: got %b expected 0", update_en); end
    tests_run++; if (pc_bits !== 16'h0000) begin tests_failed++; $display("FAIL reset_pc: got %h expected 0000", pc_bits); end
    tests_run++; if (increment_decrement !== 1'b0) begin tests_failed++; $display("FAIL reset_inc: got %b expected 0", increment_decrement); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_hit();
    tag_not_added = 1'b0;
    resolve_valid = 1'b1; resolve_pc = 16'h0A14; resolve_taken = 1'b1;
    step();
    resolve_valid = 1'b0;
    tests_run++; if (occupancy !== 3'd1) begin tests_failed++; $display("FAIL hit_occ1: got %0d expected 1", occupancy); end
    tests_run++; if (update_en !== 1'b0) begin tests_failed++; $display("FAIL hit_idle_upd: got %b expected 0", update_en); end
    tests_run++; if (pc_bits !== 16'h0000) begin tests_failed++; $display("FAIL hit_idle_pc: got %h expected 0000", pc_bits); end
    step();
    tests_run++; if (update_en !== 1'b1) begin tests_failed++; $display("FAIL hit_upd: got %b expected 1", update_en); end
    tests_run++; if (pc_bits !== 16'h0A14) begin tests_failed++; $display("FAIL hit_pc: got %h expected 0a14", pc_bits); end
    tests_run++; if (increment_decrement !== 1'b1) begin tests_failed++; $display("FAIL hit_inc: got %b expected 1", increment_decrement); end
    step();
    tests_run++; if (update_en !== 1'b0) begin tests_failed++; $display("FAIL hit_upd_end: got %b expected 0", update_en); end
    tests_run++; if (occupancy !== 3'd0) begin tests_failed++; $display("FAIL hit_occ0: got %0d expected 0", occupancy); end
  endtask

  task automatic test_miss();
    int s0;
    s0 = strobes;
    tag_not_added = 1'b1;
    resolve_valid = 1'b1; resolve_pc = 16'h0C14; resolve_taken = 1'b0;
    step();
    resolve_valid = 1'b0;
    step();
    tests_run++; if (update_en !== 1'b0) begin tests_failed++; $display("FAIL miss_lookup_upd: got %b expected 0", update_en); end
    tests_run++; if (pc_bits !== 16'h0C14) begin tests_failed++; $display("FAIL miss_lookup_pc: got %h expected 0c14", pc_bits); end
    step();
    tests_run++; if (update_en !== 1'b0) begin tests_failed++; $display("FAIL miss_alloc_upd: got %b expected 0", update_en); end
    tests_run++; if (pc_bits !== 16'h0C14) begin tests_failed++; $display("FAIL miss_alloc_pc: got %h expected 0c14", pc_bits); end
    step();
    tests_run++; if (update_en !== 1'b1) begin tests_failed++; $display("FAIL miss_update_upd: got %b expected 1", update_en); end
    tests_run++; if (increment_decrement !== 1'b0) begin tests_failed++; $display("FAIL miss_inc: got %b expected 0", increment_decrement); end
    step();
    tests_run++; if (occupancy !== 3'd0) begin tests_failed++; $display("FAIL miss_occ0: got %0d expected 0", occupancy); end
    tests_run++; if (strobes - s0 !== 1) begin tests_failed++; $display("FAIL miss_strobes: got %0d expected 1", strobes - s0); end
    tag_not_added = 1'b0;
  endtask

  task automatic test_fill_overflow();
    logic [16:0] exp;
    bht_stall = 1'b1;
    tag_not_added = 1'b0;
    for (int i = 0; i < 5; i++) begin
      resolve_valid = 1'b1;
      resolve_pc    = 16'h1000 + 16'(i);
      resolve_taken = i[0];
      step();
      if (i == 3) begin
        tests_run++; if (occupancy !== 3'd4) begin tests_failed++; $display("FAIL fill_occ4: got %0d expected 4", occupancy); end
        tests_run++; if (resolve_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_ready: got %b expected 0", resolve_ready); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL fill_ovf_early: got %b expected 0", overflow); end
      end
    end
    resolve_valid = 1'b0;
    tests_run++; if (occupancy !== 3'd4) begin tests_failed++; $display("FAIL ovf_occ: got %0d expected 4", occupancy); end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    log_q.delete();
    bht_stall = 1'b0;
    repeat (40) step();
    tests_run++; if (log_q.size() !== 4) begin tests_failed++; $display("FAIL fill_count: got %0d expected 4", log_q.size()); end
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      exp = {16'h1000 + 16'(i), i[0]};
      tests_run++; if (log_q[i] !== exp) begin tests_failed++; $display("FAIL fill_order[%0d]: got %h expected %h", i, log_q[i], exp); end
    end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_back_to_back();
    int sent;
    int max_occ;
    logic [16:0] exp;
    apply_reset();
    tag_not_added = 1'b0;
    bht_stall = 1'b0;
    log_q.delete();
    sent = 0;
    max_occ = 0;
    for (int c = 0; c < 80 && sent < 10; c++) begin
      resolve_valid = resolve_ready;
      resolve_pc    = 16'h2000 + 16'(sent * 4);
      resolve_taken = ((sent % 3) == 0);
      if (resolve_ready) sent++;
      step();
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
    end
    resolve_valid = 1'b0;
    repeat (30) step();
    tests_run++; if (sent !== 10) begin tests_failed++; $display("FAIL b2b_sent: got %0d expected 10", sent); end
    tests_run++; if (max_occ > 4) begin tests_failed++; $display("FAIL b2b_max_occ: got %0d expected <=4", max_occ); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL b2b_ovf: got %b expected 0", overflow); end
    tests_run++; if (occupancy !== 3'd0) begin tests_failed++; $display("FAIL b2b_occ: got %0d expected 0", occupancy); end
    tests_run++; if (log_q.size() !== 10) begin tests_failed++; $display("FAIL b2b_count: got %0d expected 10", log_q.size()); end
    for (int i = 0; i < 10 && i < log_q.size(); i++) begin
      exp = {16'h2000 + 16'(i * 4), ((i % 3) == 0)};
      tests_run++; if (log_q[i] !== exp) begin tests_failed++; $display("FAIL b2b_order[%0d]: got %h expected %h", i, log_q[i], exp); end
    end
  endtask

  task automatic test_reset_mid_alloc();
    int s0;
    apply_reset();
    bht_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      resolve_valid = 1'b1;
      resolve_pc    = 16'h3000 + 16'(i);
      resolve_taken = 1'b1;
      step();
    end
    resolve_valid = 1'b0;
    tag_not_added = 1'b1;
    bht_stall = 1'b0;
    step();
    step();
    tests_run++; if (pc_bits !== 16'h3000) begin tests_failed++; $display("FAIL alloc_pc: got %h expected 3000", pc_bits); end
    tests_run++; if (occupancy !== 3'd3) begin tests_failed++; $display("FAIL alloc_occ: got %0d expected 3", occupancy); end
    #2;
    reset = 1'b0;
    #1;
    tests_run++; if (occupancy !== 3'd0) begin tests_failed++; $display("FAIL rst_mid_occ: got %0d expected 0", occupancy); end
    tests_run++; if (pc_bits !== 16'h0000) begin tests_failed++; $display("FAIL rst_mid_pc: got %h expected 0000", pc_bits); end
    tests_run++; if (increment_decrement !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_inc: got %b expected 0", increment_decrement); end
    tests_run++; if (update_en !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_upd: got %b expected 0", update_en); end
    tests_run++; if (resolve_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_ready: got %b expected 1", resolve_ready); end
    step();
    reset = 1'b1;
    tag_not_added = 1'b0;
    s0 = strobes;
    repeat (6) step();
    tests_run++; if (strobes - s0 !== 0) begin tests_failed++; $display("FAIL rst_no_strobe: got %0d expected 0", strobes - s0); end
    tests_run++; if (occupancy !== 3'd0) begin tests_failed++; $display("FAIL rst_after_occ: got %0d expected 0", occupancy); end
    resolve_valid = 1'b1; resolve_pc = 16'h4444; resolve_taken = 1'b0;
    step();
    resolve_valid = 1'b0;
    repeat (4) step();
    tests_run++; if (strobes - s0 !== 1) begin tests_failed++; $display("FAIL rst_new_strobe: got %0d expected 1", strobes - s0); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    strobes = 0;
    reset = 1'b0;
    resolve_valid = 1'b0;
    resolve_pc = 16'h0000;
    resolve_taken = 1'b0;
    bht_stall = 1'b0;
    tag_not_added = 1'b0;
    test_reset();
    test_hit();
    test_miss();
    test_fill_overflow();
    test_back_to_back();
    test_reset_mid_alloc();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
